// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, the decoded event record and the list of
// controller/status bytes that never form a key event.
package ps2_pkg;

   localparam logic [7:0] PS2_EXTEND     = 8'hE0;
   localparam logic [7:0] PS2_BREAK      = 8'hF0;
   localparam int         PS2_FRAME_BITS = 11;
   localparam int         PS2_NUM_NONKEY = 6;
   localparam logic [8*PS2_NUM_NONKEY-1:0] PS2_NONKEY_CODES =
      {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

   typedef struct packed {
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } ps2_evt_t;

   function automatic logic ps2_is_nonkey(input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < PS2_NUM_NONKEY; i++) begin
         if (PS2_NONKEY_CODES[8*i +: 8] == b) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/ps2_key_decoder_rx_frame.sv
// PS/2 frame receiver: synchronises and de-glitches the bus, shifts in one
// 11-bit frame and reports a good byte, a parity error or a framing error.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BW = $clog2(PS2_FRAME_BITS);
   localparam logic [BW-1:0] STOP_BIT = BW'(PS2_FRAME_BITS - 1);

   logic [1:0]    clk_sync_q, clk_sync_d;
   logic [1:0]    data_sync_q, data_sync_d;
   logic          filt_q, filt_d;
   logic [FW-1:0] flt_cnt_q, flt_cnt_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [8:0]    shift_q, shift_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          byte_valid_q, byte_valid_d;
   logic [7:0]    byte_data_q, byte_data_d;
   logic          parity_err_q, parity_err_d;
   logic          frame_err_q, frame_err_d;
   logic          fall;

   // The filtered clock only moves once FILTER_LEN samples in a row disagree with it.
   always_comb begin
      clk_sync_d  = {clk_sync_q[0], ps2_clk};
      data_sync_d = {data_sync_q[0], ps2_data};
      filt_d      = filt_q;
      flt_cnt_d   = '0;
      if (clk_sync_q[1] != filt_q) begin
         if (flt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
         else flt_cnt_d = flt_cnt_q + 1'b1;
      end
   end

   assign fall = filt_q & ~filt_d;

   // bit_cnt 0 is idle; 1..9 collect d0..d7 and parity; STOP_BIT checks the frame.
   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      to_cnt_d     = to_cnt_q;
      byte_valid_d = 1'b0;
      byte_data_d  = byte_data_q;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      if (fall) begin
         to_cnt_d = '0;
         if (bit_cnt_q == '0) begin
            if (!data_sync_q[1]) bit_cnt_d = BW'(1);
         end else if (bit_cnt_q == STOP_BIT) begin
            bit_cnt_d = '0;
            if (!(^shift_q)) begin
               parity_err_d = 1'b1;
            end else if (!data_sync_q[1]) begin
               frame_err_d = 1'b1;
            end else begin
               byte_valid_d = 1'b1;
               byte_data_d  = shift_q[7:0];
            end
         end else begin
            shift_d   = {data_sync_q[1], shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
      end else if (bit_cnt_q != '0) begin
         if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            bit_cnt_d   = '0;
            to_cnt_d    = '0;
            frame_err_d = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end else begin
         to_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_q   <= 2'b11;
         data_sync_q  <= 2'b11;
         filt_q       <= 1'b1;
         flt_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         to_cnt_q     <= '0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= '0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         clk_sync_q   <= clk_sync_d;
         data_sync_q  <= data_sync_d;
         filt_q       <= filt_d;
         flt_cnt_q    <= flt_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         to_cnt_q     <= to_cnt_d;
         byte_valid_q <= byte_valid_d;
         byte_data_q  <= byte_data_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign byte_valid = byte_valid_q;
   assign byte_data  = byte_data_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: turns received bytes into make/break events, tracks a
// programmable key table and queues every event in a first-word fall-through FIFO.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int NUM_KEYS       = 8,
   parameter int FIFO_DEPTH     = 8,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ps2_clk,
   input  logic                  ps2_data,
   input  logic [NUM_KEYS*9-1:0] key_cfg,
   output logic [NUM_KEYS-1:0]   key_down,
   output logic [NUM_KEYS-1:0]   key_press,
   output logic                  evt_valid,
   output logic [9:0]            evt_data,
   input  logic                  evt_ready,
   output logic                  evt_overflow,
   input  logic                  evt_clear,
   output logic                  parity_err,
   output logic                  frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          ext_q, ext_d, brk_q, brk_d;
   logic          evt_push;
   ps2_evt_t      evt_new;
   logic [NUM_KEYS-1:0] key_down_q, key_down_d, key_press_q, key_press_d;
   ps2_evt_t      mem_q [FIFO_DEPTH];
   ps2_evt_t      mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          pop, full, do_push;

   ps2_rx_frame #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .parity_err(parity_err),
      .frame_err (frame_err)
   );

   // Prefix bytes accumulate; any completed, discarded or broken frame clears them.
   always_comb begin
      ext_d    = ext_q;
      brk_d    = brk_q;
      evt_push = 1'b0;
      evt_new  = '{brk: brk_q, ext: ext_q, code: byte_data};
      if (parity_err || frame_err) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (byte_valid) begin
         if (byte_data == PS2_EXTEND) begin
            ext_d = 1'b1;
         end else if (byte_data == PS2_BREAK) begin
            brk_d = 1'b1;
         end else begin
            ext_d    = 1'b0;
            brk_d    = 1'b0;
            evt_push = !ps2_is_nonkey(byte_data);
         end
      end
   end

   always_comb begin
      key_down_d  = key_down_q;
      key_press_d = '0;
      if (evt_push) begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_cfg[9*i +: 9] == {evt_new.ext, evt_new.code}) begin
               key_down_d[i]  = !evt_new.brk;
               key_press_d[i] = !evt_new.brk && !key_down_q[i];
            end
         end
      end
   end

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
   always_comb begin
      pop      = (count_q != '0) && evt_ready;
      full     = (count_q == (AW+1)'(FIFO_DEPTH));
      do_push  = evt_push && (!full || pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = evt_new;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      ovf_d = ovf_q;
      if (evt_clear) ovf_d = 1'b0;
      else if (evt_push && full && !pop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         key_down_q  <= '0;
         key_press_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         key_down_q  <= key_down_d;
         key_press_q <= key_press_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         mem_q       <= mem_d;
      end
   end

   assign key_down     = key_down_q;
   assign key_press    = key_press_q;
   assign evt_valid    = (count_q != '0);
   assign evt_data     = mem_q[rd_ptr_q];
   assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: bit-bangs PS/2 frames and checks the outputs
// against a byte-level model of prefixes, key table and event queue.
module tb_ps2_key_decoder;

   localparam int NUM_KEYS       = 8;
   localparam int FIFO_DEPTH     = 4;
   localparam int FILTER_LEN     = 4;
   localparam int TIMEOUT_CYCLES = 500;
   localparam int HALF           = 40;

   logic                  clk = 1'b0;
   logic                  rst, ps2_clk, ps2_data, evt_ready, evt_clear;
   logic [NUM_KEYS*9-1:0] key_cfg;
   logic [NUM_KEYS-1:0]   key_down, key_press;
   logic                  evt_valid, evt_overflow, parity_err, frame_err;
   logic [9:0]            evt_data;

   always #5 clk = ~clk;

   ps2_key_decoder #(
      .NUM_KEYS      (NUM_KEYS),
      .FIFO_DEPTH    (FIFO_DEPTH),
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .key_cfg     (key_cfg),
      .key_down    (key_down),
      .key_press   (key_press),
      .evt_valid   (evt_valid),
      .evt_data    (evt_data),
      .evt_ready   (evt_ready),
      .evt_overflow(evt_overflow),
      .evt_clear   (evt_clear),
      .parity_err  (parity_err),
      .frame_err   (frame_err)
   );

   int    vec_cnt = 0;
   int    err_cnt = 0;
   longint cyc = 0;
   bit    settled = 1'b0;

   logic [9:0]          m_q[$];
   logic [NUM_KEYS-1:0] m_down = '0;
   logic                m_ovf = 1'b0, m_ext = 1'b0, m_brk = 1'b0;
   int                  m_press[NUM_KEYS] = '{default: 0};
   int                  m_par = 0, m_frm = 0;
   int                  seen_press[NUM_KEYS] = '{default: 0};
   int                  seen_par = 0, seen_frm = 0;

   logic [7:0] codes[6];
   int         base;
   longint     t0, elapsed;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic bit is_nonkey(input logic [7:0] b);
      return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
   endfunction

   function automatic logic [7:0] pick_make_code();
      logic [7:0] c;
      do c = 8'($urandom_range(1, 254));
      while (is_nonkey(c) || c == 8'hE0 || c == 8'hF0);
      return c;
   endfunction

   // Reference: what one accepted byte does to prefixes, key table and queue.
   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (is_nonkey(b)) begin
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_cfg[9*i +: 9] == {m_ext, b}) begin
               if (!m_brk && !m_down[i]) m_press[i]++;
               m_down[i] = !m_brk;
            end
         end
         if (m_q.size() == FIFO_DEPTH) m_ovf = 1'b1;
         else m_q.push_back({m_brk, m_ext, b});
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic ps2_bit(input logic b, input bit glitch);
      ps2_data = b;
      tick(HALF/2);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
      if (glitch) begin
         tick(10);
         ps2_clk = 1'b0;
         tick(2);
         ps2_clk = 1'b1;
         tick(HALF/2 - 12);
      end else begin
         tick(HALF/2);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                                input bit glitch);
      settled = 1'b0;
      ps2_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
      ps2_bit((~^b) ^ flip_par, glitch);
      ps2_bit(!bad_stop, glitch);
      ps2_data = 1'b1;
      tick(10);
      if (flip_par) begin
         m_par++;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else if (bad_stop) begin
         m_frm++;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else begin
         model_byte(b);
      end
      settled = 1'b1;
      tick(4);
   endtask

   task automatic pop_event(input bit use_lit, input logic [9:0] lit);
      if (m_q.size() == 0) return;
      if (use_lit) checkOutput("evt_head_literal", evt_data, lit);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      void'(m_q.pop_front());
      tick(2);
   endtask

   task automatic clear_overflow();
      evt_clear = 1'b1;
      tick(1);
      evt_clear = 1'b0;
      m_ovf = 1'b0;
      tick(2);
   endtask

   // Every settled cycle the DUT must agree with the model.
   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < NUM_KEYS; i++) if (key_press[i]) seen_press[i]++;
      if (parity_err) seen_par++;
      if (frame_err) seen_frm++;
      if (settled) begin
         checkOutput("key_down", key_down, m_down);
         checkOutput("evt_valid", evt_valid, m_q.size() != 0);
         if (m_q.size() != 0) checkOutput("evt_data", evt_data, m_q[0]);
         checkOutput("evt_overflow", evt_overflow, m_ovf);
         for (int i = 0; i < NUM_KEYS; i++) checkOutput("press_count", seen_press[i], m_press[i]);
         checkOutput("parity_err_count", seen_par, m_par);
         checkOutput("frame_err_count", seen_frm, m_frm);
      end
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d cycles", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b0; evt_clear = 1'b0;
      key_cfg = {9'h024, 9'h01D, 9'h015, 9'h16B, 9'h01C, 9'h05A, 9'h05A, 9'h175};
      tick(3);
      checkOutput("reset_key_down", key_down, 0);
      checkOutput("reset_key_press", key_press, 0);
      checkOutput("reset_evt_valid", evt_valid, 0);
      checkOutput("reset_evt_data", evt_data, 0);
      checkOutput("reset_evt_overflow", evt_overflow, 0);
      checkOutput("reset_errors", {parity_err, frame_err}, 0);
      rst = 1'b0;
      tick(2);
      settled = 1'b1;
      tick(5);

      // Extended make then extended break of entry 0.
      applyStimulus(8'hE0, 0, 0, 0);
      applyStimulus(8'h75, 0, 0, 0);
      checkOutput("ext_make_key_down0", key_down[0], 1);
      checkOutput("ext_make_press0", seen_press[0], 1);
      checkOutput("ext_make_evt", evt_data, 10'h175);
      applyStimulus(8'hE0, 0, 0, 0);
      applyStimulus(8'hF0, 0, 0, 0);
      applyStimulus(8'h75, 0, 0, 0);
      checkOutput("ext_break_key_down0", key_down[0], 0);
      pop_event(1, 10'h175);
      pop_event(1, 10'h375);
      checkOutput("fifo_drained", evt_valid, 0);

      // Typematic repeats: one press pulse, three events, duplicate entry follows.
      repeat (3) applyStimulus(8'h5A, 0, 0, 0);
      checkOutput("typematic_key_down", key_down[2:1], 2'b11);
      checkOutput("typematic_press1", seen_press[1], 1);
      checkOutput("typematic_press2", seen_press[2], 1);
      repeat (3) pop_event(1, 10'h05A);

      // Corrupted frames.
      applyStimulus(8'h5A, 1, 0, 0);
      checkOutput("parity_err_pulses", seen_par, 1);
      checkOutput("parity_no_event", evt_valid, 0);
      applyStimulus(8'h1C, 0, 1, 0);
      checkOutput("stop_err_pulses", seen_frm, 1);
      checkOutput("stop_no_key", key_down[3], 0);

      // Partial frame followed by silence must time out.
      settled = 1'b0;
      ps2_bit(1'b0, 0); ps2_bit(1'b1, 0); ps2_bit(1'b0, 0); ps2_bit(1'b1, 0);
      ps2_data = 1'b1;
      base = seen_frm;
      t0 = cyc;
      for (int k = 0; k < 2*TIMEOUT_CYCLES && seen_frm == base; k++) tick(1);
      elapsed = cyc - t0 + (HALF + HALF/2);
      checkOutput("timeout_frame_err", seen_frm - base, 1);
      checkOutput("timeout_latency_ok",
                  (elapsed >= TIMEOUT_CYCLES) && (elapsed <= TIMEOUT_CYCLES + 12), 1);
      m_frm++;
      m_ext = 1'b0;
      m_brk = 1'b0;
      settled = 1'b1;
      tick(4);
      applyStimulus(8'h1C, 0, 0, 0);
      checkOutput("after_timeout_evt", evt_data, 10'h01C);
      pop_event(1, 10'h01C);

      // Overflow: six makes into a four-deep FIFO.
      for (int k = 0; k < 6; k++) begin
         codes[k] = pick_make_code();
         applyStimulus(codes[k], 0, 0, 0);
      end
      checkOutput("overflow_set", evt_overflow, 1);
      for (int k = 0; k < 4; k++) pop_event(1, {2'b00, codes[k]});
      checkOutput("overflow_drained", evt_valid, 0);
      clear_overflow();
      checkOutput("overflow_cleared", evt_overflow, 0);

      // Glitches on ps2_clk while idle with data low, then inside a frame.
      settled = 1'b0;
      ps2_data = 1'b0;
      repeat (5) begin
         tick(8);
         ps2_clk = 1'b0;
         tick(2);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      tick(20);
      settled = 1'b1;
      applyStimulus(8'h29, 0, 0, 1);
      checkOutput("glitch_evt", evt_data, 10'h029);
      pop_event(1, 10'h029);

      // Random byte stream with prefixes, parity errors, pops and clears.
      for (int n = 0; n < 30; n++) begin
         logic [7:0] b;
         case ($urandom_range(0, 9))
            0: b = 8'hE0;
            1: b = 8'hF0;
            2: b = 8'h5A;
            3: b = 8'h75;
            4: b = 8'h1C;
            5: b = 8'hAA;
            default: b = 8'($urandom_range(0, 255));
         endcase
         applyStimulus(b, $urandom_range(0, 15) == 0, 0, 0);
         if ($urandom_range(0, 2) == 0) pop_event(0, '0);
         if ($urandom_range(0, 7) == 0) clear_overflow();
      end

      // Reset in the middle of a frame.
      settled = 1'b0;
      repeat (5) ps2_bit(1'b0, 0);
      rst = 1'b1;
      tick(2);
      checkOutput("midrst_key_down", key_down, 0);
      checkOutput("midrst_key_press", key_press, 0);
      checkOutput("midrst_evt_valid", evt_valid, 0);
      checkOutput("midrst_evt_data", evt_data, 0);
      checkOutput("midrst_flags", {evt_overflow, parity_err, frame_err}, 0);
      m_q.delete();
      m_down = '0;
      m_ovf = 1'b0;
      m_ext = 1'b0;
      m_brk = 1'b0;
      ps2_data = 1'b1;
      rst = 1'b0;
      tick(5);
      settled = 1'b1;
      applyStimulus(8'h5A, 0, 0, 0);
      checkOutput("post_rst_key_down", key_down, 8'b0000_0110);
      checkOutput("post_rst_evt", evt_data, 10'h05A);

      settled = 1'b0;
      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Parametrised PS/2 keyboard receiver and decoder; successor to the fixed five-key arrow/enter decoder.
- Adds ps2_clk glitch filtering, odd-parity and stop-bit checking, and a mid-frame timeout.
- Provides a run-time-programmable key table of NUM_KEYS entries (level and make-pulse per key) and an event FIFO carrying every decoded make/break event.
- Sits between the board PS/2 pins and game/menu control logic.

Parameters:
NUM_KEYS, 8, number of key-table entries
FIFO_DEPTH, 8, event FIFO depth; power of two, >=2
FILTER_LEN, 4, consecutive equal synchronised samples required before the filtered ps2_clk changes; >=1
TIMEOUT_CYCLES, 50000, clk cycles with no filtered falling edge mid-frame before abort

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
ps2_clk  in  1  raw PS/2 clock, asynchronous to clk
ps2_data  in  1  raw PS/2 data, asynchronous to clk
key_cfg  in  NUM_KEYS*9  entry i = bits [9i+8:9i]: bit 8 = extended (E0) flag, bits 7:0 = scan code; quasi-static
key_down  out  NUM_KEYS  level: entry i currently held
key_press  out  NUM_KEYS  one-cycle pulse on a new make of entry i
evt_valid  out  1  FIFO not empty
evt_data  out  10  {break, extend, code[7:0]} at FIFO head
evt_ready  in  1  pop when evt_valid & evt_ready
evt_overflow  out  1  sticky: an event was dropped because the FIFO was full
evt_clear  in  1  clears evt_overflow
parity_err  out  1  one-cycle pulse: frame with bad parity
frame_err  out  1  one-cycle pulse: bad stop bit or timeout

Behaviour:
- Reset values:
  - All outputs 0.
  - Sync flops and filtered clock 1.
  - Bit counter 0; extend/break prefixes cleared; FIFO empty.
- Input conditioning:
  - ps2_clk and ps2_data each pass through 2 sync flops.
  - The filtered clock takes the new value after FILTER_LEN consecutive equal samples.
  - Sampling occurs on the cycle of a filtered 1->0 transition, using the synchronised ps2_data.
- Frame format: start(0), d0..d7 (LSB first), odd parity, stop(1).
  - IDLE: a start sample of 1 is ignored and the receiver stays idle.
  - Parity mismatch: parity_err pulses, byte discarded, prefixes cleared.
  - Stop bit 0: frame_err pulses, byte discarded, prefixes cleared.
- Timeout: bit counter nonzero and TIMEOUT_CYCLES elapsed since the last filtered falling edge:
  - return to IDLE, frame_err pulses, prefixes cleared;
  - the counter restarts on every falling edge.
- Byte decode (valid byte at cycle N, i.e. the stop-bit edge):
  - 0xE0: set extend.
  - 0xF0: set break; extend is kept.
  - 0xAA, 0xFA, 0xEE, 0xFE, 0x00, 0xFF: discarded, prefixes cleared.
  - Any other byte forms event {break, extend, code}; prefixes clear at N+1.
- Key table, updated at N+1 for every entry i with key_cfg[i] == {extend, code}:
  - key_down[i] <= !break.
  - key_press[i] pulses at N+1 only if it is a make and key_down[i] was 0, so typematic repeats give no pulse.
  - Duplicate table entries update together.
- Event FIFO (registered, first-word fall-through):
  - Every event is written at N+1 and evt_valid rises at N+1 if the FIFO was empty.
  - Push when full with no pop in the same cycle: event dropped, evt_overflow <= 1.
  - Push and pop in the same cycle while full: both succeed.
  - evt_clear has priority over setting evt_overflow in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is clog2(FIFO_DEPTH)+1 bits.
- Reset mid-frame: immediate abort; a partial frame never produces a byte.

Decomposition:
- Shared package ps2_pkg:
  - constants PS2_EXTEND=8'hE0, PS2_BREAK=8'hF0, and the non-key code list;
  - typedef ps2_evt_t {brk, ext, code[7:0]};
  - localparam PS2_FRAME_BITS=11.
- Sub-module ps2_rx_frame covers sync, filter, shifter, parity check and timeout.
  - Outputs byte_valid, byte_data[7:0], parity_err, frame_err.
  - The top level holds decode, key table and FIFO.

Test Plan:
- Setup: ps2_clk half-period 40 clk; key_cfg[0]={1,75h}, key_cfg[1]={0,5Ah}.
- Send E0,75 -> key_down[0]=1, key_press[0] one pulse, evt_data=0x175; then E0,F0,75 -> key_down[0]=0, evt_data=0x375.
- Send 5A three times (typematic) -> key_down[1]=1, exactly one key_press[1] pulse, three FIFO events 0x05A.
- Send 5A with parity bit flipped -> parity_err pulse; no key or FIFO change. Send a frame with stop=0 -> frame_err pulse.
- TIMEOUT_CYCLES=500: stop ps2_clk after 4 bits -> frame_err at 500 cycles; next full frame 1C decodes as 0x01C.
- FIFO_DEPTH=4, evt_ready=0, send 6 make codes -> 4 held, evt_overflow=1. Pop all -> original order preserved. Pulse evt_clear -> evt_overflow=0.
- Glitches: 2-cycle low pulses on ps2_clk with FILTER_LEN=4 -> no bit sampled. Assert rst mid-frame -> all outputs 0 and the next frame decodes correctly.
